adc_spi_reader: RTL and testbench
=================================

Name: adc_spi_reader

Overview:
- SPI master that reads a dual-channel 12-bit serial ADC (MCP3202-style command framing) and presents parallel voltage and current samples.
- Its outputs feed the solar monitor's 12-bit voltage/current inputs. It replaces the external parallel ADC bus on io_in[23:0] with a 4-pin serial interface.
- One start request runs two back-to-back frames, channel 0 (voltage) then channel 1 (current). Both results are published together with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 4, number of wb_clk_i cycles per SCLK half-period; also sets CS setup and hold time; legal range is 1 or more.
- FRAME_BITS, 16, SCLK cycles per frame; fixed at 16 (command nibble plus 12 data bits).

Ports:
- wb_clk_i  input  1  single system clock; all logic on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- start  input  1  request a voltage+current conversion pair; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until IDLE is re-entered.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sclk  output  1  SPI clock, mode 0 (idles low).
- adc_mosi  output  1  command bit to the ADC.
- adc_miso  input  1  data bit from the ADC.
- voltage  output  12  last channel-0 result.
- current  output  12  last channel-1 result.
- valid  output  1  one-cycle pulse when voltage and current update.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge, any state, including mid-frame):
  - Next cycle: state IDLE, adc_cs_n=1, adc_sclk=0, adc_mosi=0, busy=0, valid=0, voltage=0, current=0.
  - All counters, shift registers and staging registers are cleared.
- Command word per frame, sent MSB first: {start=1, SGL=1, ODD=ch, MSBF=1, 12'b0}. This gives 0xD000 for ch0 and 0xF000 for ch1.
- States and transitions:
  - IDLE: cs_n=1, sclk=0, mosi=0.
    - start=1 at edge k → CS_SETUP with ch=0; from cycle k+1, cs_n=0 and busy=1.
  - CS_SETUP: cs_n=0, sclk=0, mosi=cmd[15]; lasts CLK_DIV cycles → SHIFT.
  - SHIFT: a divider counts 0..CLK_DIV-1 and toggles sclk at terminal count.
    - On each 0→1 sclk transition: shift adc_miso into a 16-bit receive register, LSB in.
    - On each 1→0 transition: mosi presents the next command bit; after the 16th falling edge, mosi=0.
    - Lasts exactly 32*CLK_DIV cycles (16 full SCLK periods), ending with sclk=0 → CS_HOLD.
  - CS_HOLD: cs_n=1, sclk=0 for CLK_DIV cycles.
    - On entry, receive register bits [11:0] are copied into the staging register for ch.
    - If ch=0: set ch=1 and go to CS_SETUP.
    - If ch=1: go to IDLE.
  - On the IDLE re-entry cycle: voltage and current load from staging simultaneously, valid=1 for that single cycle, busy=0.
- Latency: start accepted at edge k gives valid high during cycle k+1+68*CLK_DIV (272 cycles after acceptance for CLK_DIV=4).
- Outputs never change between valid pulses. A partial pair interrupted by reset is discarded.
- start while busy=1 is ignored; it is not queued.
- start held high continuously: a new pair begins on the edge after the valid cycle, giving exactly one IDLE cycle between pairs.
- The first 4 received bits (ADC null/hi-Z period) are discarded. Received data is MSB-first, so the result is rx[11:0] with rx[11] being the first of the last 12 bits sampled.
- CLK_DIV=1: sclk toggles every cycle; setup and hold are 1 cycle each; every rule above still holds.
- adc_miso is sampled only on sclk rising transitions; it is ignored in all other cycles and states.

Test Plan:
1. Reset state: assert wb_rst_i for 2 cycles → cs_n=1, sclk=0, mosi=0, busy=0, valid=0, voltage=current=0.
2. Basic pair, CLK_DIV=4: ADC model returns 0xABC on ch0 and 0x123 on ch1; pulse start at edge k → mosi frames decode to 0xD000 then 0xF000; valid pulses once at cycle k+273 with voltage=0xABC, current=0x123; cs_n high exactly 4 cycles between frames.
3. Busy rejection: pulse start again 50 cycles into the pair → no extra frame; exactly 2 cs_n low windows; one valid pulse.
4. Reset mid-frame: assert wb_rst_i during the 8th SCLK of the ch1 frame → next cycle cs_n=1, sclk=0, busy=0; voltage/current remain 0; no valid pulse.
5. CLK_DIV=1 boundaries: ADC returns 0xFFF then 0x000 → voltage=0xFFF, current=0x000, valid at k+69; the 4 leading null bits, driven to 1 by the model, are not visible in the results.
6. Continuous start=1: three consecutive pairs with data 0x001/0x800, 0x555/0xAAA, 0x7FF/0x400 → three valid pulses spaced 68*CLK_DIV+1 cycles apart, each carrying the matching value pair.

Source files
------------

// File: rtl/adc_spi_reader.sv
// SPI master for an MCP3202-style dual-channel 12-bit ADC. One start reads channel 0
// (voltage) then channel 1 (current) and publishes both results with a one-cycle valid.
module adc_spi_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  output logic        busy,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [11:0] voltage,
  output logic [11:0] current,
  output logic        valid
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * FRAME_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [DIV_W-1:0]  div_r;
  logic [HALF_W-1:0] half_r;
  logic              ch_r, sclk_r, cs_n_r, mosi_r, busy_r, valid_r;
  logic [14:0]       cmd_r;
  logic [11:0]       rx_r, stage_v_r, stage_c_r, voltage_r, current_r;
  logic              div_tc_s, tick_s, setup_entry_s, sclk_rise_s, sclk_fall_s;
  logic              frame_end_s, pair_done_s;

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_nxt_s = state_r;
    tick_s      = 1'b0;
    div_tc_s    = (div_r == DIV_LAST);
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CS_SETUP;
        else       state_nxt_s = IDLE;
      end
      CS_SETUP: begin
        if (div_tc_s) state_nxt_s = SHIFT;
        else          state_nxt_s = CS_SETUP;
      end
      SHIFT: begin
        tick_s = div_tc_s;
        if (div_tc_s && (half_r == HALF_LAST)) state_nxt_s = CS_HOLD;
        else                                   state_nxt_s = SHIFT;
      end
      CS_HOLD: begin
        if (div_tc_s && ch_r)  state_nxt_s = IDLE;
        else if (div_tc_s)     state_nxt_s = CS_SETUP;
        else                   state_nxt_s = CS_HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
    sclk_rise_s   = tick_s & ~sclk_r;
    sclk_fall_s   = tick_s & sclk_r;
    frame_end_s   = tick_s & (half_r == HALF_LAST);
    setup_entry_s = (state_nxt_s == CS_SETUP) && (state_r != CS_SETUP);
    pair_done_s   = (state_r == CS_HOLD) && div_tc_s && ch_r;
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Bit-timing divider, half-period counter, SCLK and channel select
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_r  <= '0;
      half_r <= '0;
      sclk_r <= 1'b0;
      ch_r   <= 1'b0;
    end else begin
      if ((state_r == IDLE) || div_tc_s) div_r <= '0;
      else                               div_r <= div_r + DIV_W'(1);
      if (tick_s)                 half_r <= half_r + HALF_W'(1);
      else if (state_r != SHIFT)  half_r <= '0;
      else                        half_r <= half_r;
      sclk_r <= sclk_r ^ tick_s;
      if (state_r == IDLE)                      ch_r <= 1'b0;
      else if ((state_r == CS_HOLD) && div_tc_s) ch_r <= 1'b1;
      else                                      ch_r <= ch_r;
    end
  end

  // Command shift-out on falling SCLK; response shift-in on rising SCLK.
  // Only the last 12 received bits are kept, so the null bits fall off the top.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_r  <= 15'h0000;
      mosi_r <= 1'b0;
      rx_r   <= 12'h000;
    end else begin
      if (setup_entry_s) begin
        cmd_r  <= {1'b1, (state_r == CS_HOLD), 1'b1, 12'h000};
        mosi_r <= 1'b1;
      end else if (sclk_fall_s) begin
        cmd_r  <= {cmd_r[13:0], 1'b0};
        mosi_r <= cmd_r[14];
      end else begin
        cmd_r  <= cmd_r;
        mosi_r <= mosi_r;
      end
      if (sclk_rise_s) rx_r <= {rx_r[10:0], adc_miso};
      else             rx_r <= rx_r;
    end
  end

  // Result staging, publication and registered interface outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stage_v_r <= 12'h000;
      stage_c_r <= 12'h000;
      voltage_r <= 12'h000;
      current_r <= 12'h000;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      cs_n_r    <= 1'b1;
    end else begin
      if (frame_end_s && !ch_r) stage_v_r <= rx_r;
      else                      stage_v_r <= stage_v_r;
      if (frame_end_s && ch_r)  stage_c_r <= rx_r;
      else                      stage_c_r <= stage_c_r;
      if (pair_done_s) begin
        voltage_r <= stage_v_r;
        current_r <= stage_c_r;
      end else begin
        voltage_r <= voltage_r;
        current_r <= current_r;
      end
      valid_r <= pair_done_s;
      busy_r  <= (state_nxt_s != IDLE);
      cs_n_r  <= ~((state_nxt_s == CS_SETUP) || (state_nxt_s == SHIFT));
    end
  end

  assign busy     = busy_r;
  assign adc_cs_n = cs_n_r;
  assign adc_sclk = sclk_r;
  assign adc_mosi = mosi_r;
  assign voltage  = voltage_r;
  assign current  = current_r;
  assign valid    = valid_r;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=1,
// each talking to a behavioural MCP3202-style ADC that decodes the channel from MOSI.
module tb_adc_spi_reader;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        miso  [2];
  logic        busy  [2];
  logic        cs_n  [2];
  logic        sclk  [2];
  logic        mosi  [2];
  logic        valid [2];
  logic [11:0] volt  [2];
  logic [11:0] cur   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  adc_spi_reader #(.CLK_DIV(4), .FRAME_BITS(16)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .start(start[0]), .busy(busy[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_mosi(mosi[0]), .adc_miso(miso[0]),
    .voltage(volt[0]), .current(cur[0]), .valid(valid[0])
  );

  adc_spi_reader #(.CLK_DIV(1), .FRAME_BITS(16)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .start(start[1]), .busy(busy[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_mosi(mosi[1]), .adc_miso(miso[1]),
    .voltage(volt[1]), .current(cur[1]), .valid(valid[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: null bits are driven high, data changes after each falling SCLK
  logic        cs_q   [2];
  logic        sclk_q [2];
  logic        chm    [2];
  int          idx    [2];
  int          rises  [2];
  int          ncmd   [2];
  logic [15:0] mcap   [2];
  logic [15:0] cmd_log  [2][16];
  logic [11:0] adc_data [2][2];
  logic [11:0] word_m;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n[g] === 1'b1) begin
        if (cs_q[g] === 1'b0) begin
          cmd_log[g][ncmd[g] % 16] = mcap[g];
          ncmd[g] = ncmd[g] + 1;
        end
        idx[g] = 0; rises[g] = 0; mcap[g] = 16'h0000; miso[g] = 1'b1;
      end else if (sclk[g] === 1'b1 && sclk_q[g] === 1'b0) begin
        mcap[g] = {mcap[g][14:0], mosi[g]};
        rises[g] = rises[g] + 1;
      end else if (sclk[g] === 1'b0 && sclk_q[g] === 1'b1) begin
        idx[g] = idx[g] + 1;
        if (idx[g] == 4) chm[g] = mcap[g][1];
        word_m = adc_data[g][chm[g]];
        if (idx[g] < 4)       miso[g] = 1'b1;
        else if (idx[g] < 16) miso[g] = word_m[15 - idx[g]];
        else                  miso[g] = 1'b0;
      end
      cs_q[g] = cs_n[g];
      sclk_q[g] = sclk[g];
    end
  end

  // Observation results from watch()
  int          w_nvalid, w_nlow, w_gap;
  int          w_t [4];
  logic [11:0] w_v [4];
  logic [11:0] w_c [4];

  task automatic watch(input int g, input int ncyc, input int poke_at);
    logic prev_cs;
    int   hi_run;
    w_nvalid = 0; w_nlow = 0; w_gap = -1; hi_run = 0; prev_cs = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (valid[g]) begin
        if (w_nvalid < 4) begin
          w_t[w_nvalid] = cyc; w_v[w_nvalid] = volt[g]; w_c[w_nvalid] = cur[g];
        end
        w_nvalid++;
      end
      if (!cs_n[g] && prev_cs) begin w_nlow++; w_gap = hi_run; end
      hi_run  = cs_n[g] ? hi_run + 1 : 0;
      prev_cs = cs_n[g];
      if (i == poke_at)          start[g] = 1'b1;
      else if (i == poke_at + 1) start[g] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst[0] = 1'b1; rst[1] = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
    adc_data[0][0] = 12'h000; adc_data[0][1] = 12'h000;
    adc_data[1][0] = 12'h000; adc_data[1][1] = 12'h000;
    repeat (2) @(negedge clk);
    n_cmp++; if (cs_n[0] !== 1'b1)    begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n[0]); end
    n_cmp++; if (sclk[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk[0]); end
    n_cmp++; if (mosi[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi[0]); end
    n_cmp++; if (busy[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    n_cmp++; if (valid[0] !== 1'b0)   begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid[0]); end
    n_cmp++; if (volt[0] !== 12'h000) begin n_bad++; $display("FAIL reset_voltage: got %h want 000", volt[0]); end
    n_cmp++; if (cur[0] !== 12'h000)  begin n_bad++; $display("FAIL reset_current: got %h want 000", cur[0]); end
    n_cmp++; if (cs_n[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_bad++; $display("FAIL reset_div1: got cs_n=%b busy=%b want 1/0", cs_n[1], busy[1]);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_pair;
    int acc, base;
    adc_data[0][0] = 12'hABC; adc_data[0][1] = 12'h123;
    base = ncmd[0];
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; acc = cyc;
    n_cmp++; if (busy[0] !== 1'b1 || cs_n[0] !== 1'b0 || mosi[0] !== 1'b1) begin
      n_bad++; $display("FAIL basic_accept: got busy=%b cs_n=%b mosi=%b want 1/0/1", busy[0], cs_n[0], mosi[0]);
    end
    watch(0, 400, -1);
    n_cmp++; if (w_nvalid !== 1)        begin n_bad++; $display("FAIL basic_valid_count: got %0d want 1", w_nvalid); end
    n_cmp++; if (w_t[0] - acc !== 272)  begin n_bad++; $display("FAIL basic_latency: got %0d want 272", w_t[0] - acc); end
    n_cmp++; if (w_v[0] !== 12'hABC)    begin n_bad++; $display("FAIL basic_voltage: got %h want abc", w_v[0]); end
    n_cmp++; if (w_c[0] !== 12'h123)    begin n_bad++; $display("FAIL basic_current: got %h want 123", w_c[0]); end
    n_cmp++; if (w_nlow !== 2)          begin n_bad++; $display("FAIL basic_cs_windows: got %0d want 2", w_nlow); end
    n_cmp++; if (w_gap !== 4)           begin n_bad++; $display("FAIL basic_cs_gap: got %0d want 4", w_gap); end
    n_cmp++; if (ncmd[0] - base !== 2)  begin n_bad++; $display("FAIL basic_frames: got %0d want 2", ncmd[0] - base); end
    n_cmp++; if (cmd_log[0][base % 16] !== 16'hD000) begin
      n_bad++; $display("FAIL basic_cmd_ch0: got %h want d000", cmd_log[0][base % 16]);
    end
    n_cmp++; if (cmd_log[0][(base + 1) % 16] !== 16'hF000) begin
      n_bad++; $display("FAIL basic_cmd_ch1: got %h want f000", cmd_log[0][(base + 1) % 16]);
    end
    n_cmp++; if (volt[0] !== 12'hABC || busy[0] !== 1'b0 || mosi[0] !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle_after: got volt=%h busy=%b mosi=%b want abc/0/0", volt[0], busy[0], mosi[0]);
    end
  endtask

  task automatic test_busy_reject;
    int acc;
    adc_data[0][0] = 12'h5A5; adc_data[0][1] = 12'h3C3;
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; acc = cyc;
    watch(0, 600, 48);
    n_cmp++; if (w_nlow !== 2)         begin n_bad++; $display("FAIL busy_cs_windows: got %0d want 2", w_nlow); end
    n_cmp++; if (w_nvalid !== 1)       begin n_bad++; $display("FAIL busy_valid_count: got %0d want 1", w_nvalid); end
    n_cmp++; if (w_t[0] - acc !== 272) begin n_bad++; $display("FAIL busy_latency: got %0d want 272", w_t[0] - acc); end
    n_cmp++; if (w_v[0] !== 12'h5A5 || w_c[0] !== 12'h3C3) begin
      n_bad++; $display("FAIL busy_values: got %h/%h want 5a5/3c3", w_v[0], w_c[0]);
    end
  endtask

  task automatic test_reset_midframe;
    int  base;
    logic found;
    adc_data[0][0] = 12'h321; adc_data[0][1] = 12'h654;
    base = ncmd[0]; found = 1'b0;
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ncmd[0] == base + 1 && rises[0] == 8) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_reach_ch1_sclk8: got %b want 1", found); end
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    n_cmp++; if (cs_n[0] !== 1'b1)    begin n_bad++; $display("FAIL mid_cs_n: got %b want 1", cs_n[0]); end
    n_cmp++; if (sclk[0] !== 1'b0)    begin n_bad++; $display("FAIL mid_sclk: got %b want 0", sclk[0]); end
    n_cmp++; if (busy[0] !== 1'b0)    begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy[0]); end
    n_cmp++; if (mosi[0] !== 1'b0 || valid[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_mosi_valid: got %b/%b want 0/0", mosi[0], valid[0]);
    end
    n_cmp++; if (volt[0] !== 12'h000 || cur[0] !== 12'h000) begin
      n_bad++; $display("FAIL mid_outputs_cleared: got %h/%h want 000/000", volt[0], cur[0]);
    end
    watch(0, 400, -1);
    n_cmp++; if (w_nvalid !== 0 || w_nlow !== 0) begin
      n_bad++; $display("FAIL mid_no_resume: got valid=%0d frames=%0d want 0/0", w_nvalid, w_nlow);
    end
    n_cmp++; if (volt[0] !== 12'h000 || cur[0] !== 12'h000) begin
      n_bad++; $display("FAIL mid_outputs_stay: got %h/%h want 000/000", volt[0], cur[0]);
    end
  endtask

  task automatic test_clkdiv1;
    int acc, base;
    adc_data[1][0] = 12'hFFF; adc_data[1][1] = 12'h000;
    base = ncmd[1];
    start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0; acc = cyc;
    watch(1, 150, -1);
    n_cmp++; if (w_nvalid !== 1)       begin n_bad++; $display("FAIL div1_valid_count: got %0d want 1", w_nvalid); end
    n_cmp++; if (w_t[0] - acc !== 68)  begin n_bad++; $display("FAIL div1_latency: got %0d want 68", w_t[0] - acc); end
    n_cmp++; if (w_v[0] !== 12'hFFF)   begin n_bad++; $display("FAIL div1_voltage: got %h want fff", w_v[0]); end
    n_cmp++; if (w_c[0] !== 12'h000)   begin n_bad++; $display("FAIL div1_current: got %h want 000", w_c[0]); end
    n_cmp++; if (w_gap !== 1)          begin n_bad++; $display("FAIL div1_cs_gap: got %0d want 1", w_gap); end
    n_cmp++; if (cmd_log[1][base % 16] !== 16'hD000 || cmd_log[1][(base + 1) % 16] !== 16'hF000) begin
      n_bad++; $display("FAIL div1_cmds: got %h/%h want d000/f000", cmd_log[1][base % 16], cmd_log[1][(base + 1) % 16]);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] ev [3];
    logic [11:0] ec [3];
    logic [11:0] gv [3];
    logic [11:0] gc [3];
    int t [3];
    int acc, n;
    ev = '{12'h001, 12'h555, 12'h7FF};
    ec = '{12'h800, 12'hAAA, 12'h400};
    adc_data[0][0] = ev[0]; adc_data[0][1] = ec[0];
    n = 0;
    start[0] = 1'b1;
    @(negedge clk); acc = cyc;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (valid[0]) begin
        if (n < 3) begin t[n] = cyc; gv[n] = volt[0]; gc[n] = cur[0]; end
        n++;
        if (n < 3) begin adc_data[0][0] = ev[n]; adc_data[0][1] = ec[n]; end
        else start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 3", n); end
    if (n >= 3) begin
      n_cmp++; if (t[0] - acc !== 272)  begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 272", t[0] - acc); end
      n_cmp++; if (t[1] - t[0] !== 273) begin n_bad++; $display("FAIL b2b_spacing_1: got %0d want 273", t[1] - t[0]); end
      n_cmp++; if (t[2] - t[1] !== 273) begin n_bad++; $display("FAIL b2b_spacing_2: got %0d want 273", t[2] - t[1]); end
      for (int p = 0; p < 3; p++) begin
        n_cmp++; if (gv[p] !== ev[p] || gc[p] !== ec[p]) begin
          n_bad++; $display("FAIL b2b_pair%0d: got %h/%h want %h/%h", p, gv[p], gc[p], ev[p], ec[p]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_pair;
    test_busy_reject;
    test_reset_midframe;
    test_clkdiv1;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
